// File: rtl/sensors_intf_nios2_qsys_0_oci_dct_packer.sv
// rtl/sensors_intf_nios2_qsys_0_oci_dct_packer.sv - packs 2-bit trace atoms into 30-bit words; optional DCT_IDLE_FLUSH_EN
module sensors_intf_nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned SLOTS       = 15,
  parameter int unsigned IDLE_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] FULL = 4'(SLOTS);

  // Word layout is fixed at 15 two-bit slots; reject any other sizing at elaboration.
  if (SLOTS * 2 != 30 || SLOTS > 15 || IDLE_CYCLES == 0) begin : g_bad_params
    $error("dct_packer: SLOTS must be 15 and IDLE_CYCLES nonzero");
  end

  state_t      state, state_n;
  logic [29:0] acc_buf, acc_buf_n;
  logic [3:0]  acc_cnt, acc_cnt_n;
  logic        out_free, accept, ship, timeout;

  assign out_free   = !dct_valid || dct_ready;
  assign atom_ready = (state != DRAIN) && (acc_cnt != FULL);
  assign accept     = atom_valid && atom_ready;

`ifdef DCT_IDLE_FLUSH_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  assign timeout = (idle_cnt == IW'(IDLE_CYCLES));

  // Idle counter: runs while a partial word sits in RUN, saturates at the timeout until shipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (accept || ship) begin
      idle_cnt <= '0;
    end else if (state == RUN && acc_cnt != 4'd0 && acc_cnt != FULL && !timeout) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Ship decision, accumulator update and next FSM state.
  always_comb begin
    ship      = out_free && (acc_cnt != 4'd0) &&
                ((acc_cnt == FULL) || (state == DRAIN) ||
                 (timeout && state == RUN && !accept));
    acc_buf_n = acc_buf;
    acc_cnt_n = acc_cnt;
    state_n   = state;
    if (ship) begin
      acc_buf_n = '0;
      acc_cnt_n = 4'd0;
    end else if (accept) begin
      for (int k = 0; k < 15; k++) begin
        if (acc_cnt == 4'(k)) acc_buf_n[2*k +: 2] = atom;
      end
      acc_cnt_n = acc_cnt + 4'd1;
    end
    case (state)
      RUN:     if (flush) state_n = DRAIN;
      DRAIN:   if (acc_cnt == 4'd0 && !dct_valid) state_n = DONE;
      DONE:    if (accept) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Accumulator and FSM state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf <= '0;
      acc_cnt <= 4'd0;
      state   <= RUN;
    end else begin
      acc_buf <= acc_buf_n;
      acc_cnt <= acc_cnt_n;
      state   <= state_n;
    end
  end

  // Output word register: load on ship, otherwise hold until the sink takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= 4'd0;
      dct_valid  <= 1'b0;
    end else if (ship) begin
      dct_buffer <= acc_buf;
      dct_count  <= acc_cnt;
      dct_valid  <= 1'b1;
    end else if (dct_ready) begin
      dct_valid  <= 1'b0;
    end
  end

  // Registered end-of-test status, tracking the FSM state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      test_ending    <= (state_n == DRAIN);
      test_has_ended <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_sensors_intf_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_sensors_intf_nios2_qsys_0_oci_dct_packer.sv - directed self-checking bench for the dct packer
module tb_sensors_intf_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        test_ending;
  logic        test_has_ended;

  int total = 0;
  int bad   = 0;

  sensors_intf_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic send_atoms(input int n, input logic [1:0] v);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 100) begin
      @(negedge clk);
      guard++;
      if (atom_ready) begin
        atom_valid = 1'b1;
        atom = v;
        sent++;
      end else begin
        atom_valid = 1'b0;
      end
    end
    @(negedge clk);
    atom_valid = 1'b0;
    total++;
    if (sent !== n) begin
      bad++;
      $display("FAIL send_atoms timeout: accepted=%0d wanted=%0d", sent, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b exp=0", dct_valid); end
    total++; if (dct_buffer !== 30'h0) begin bad++; $display("FAIL rst_buffer: got=%h exp=0", dct_buffer); end
    total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL rst_count: got=%0d exp=0", dct_count); end
    total++; if (test_ending !== 1'b0) begin bad++; $display("FAIL rst_ending: got=%b exp=0", test_ending); end
    total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL rst_ended: got=%b exp=0", test_has_ended); end
    total++; if (atom_ready !== 1'b1) begin bad++; $display("FAIL rst_atom_ready: got=%b exp=1", atom_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_full_word();
    dct_ready = 1'b1;
    send_atoms(15, 2'b01);
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid: got=%b exp=0", dct_valid); end
    total++; if (atom_ready !== 1'b0) begin bad++; $display("FAIL full_atom_ready: got=%b exp=0", atom_ready); end
    @(negedge clk);
    total++; if (dct_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got=%b exp=1", dct_valid); end
    total++; if (dct_buffer !== 30'h15555555) begin bad++; $display("FAIL full_buffer: got=%h exp=15555555", dct_buffer); end
    total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL full_count: got=%0d exp=15", dct_count); end
    @(negedge clk);
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL full_valid_drop: got=%b exp=0", dct_valid); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    dct_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (atom_ready && sent < 30) begin
        atom_valid = 1'b1;
        atom = (sent < 15) ? 2'b10 : 2'b11;
        sent++;
      end else begin
        atom_valid = 1'b0;
      end
    end
    @(negedge clk);
    atom_valid = 1'b0;
    total++; if (sent !== 30) begin bad++; $display("FAIL bp_accepted: got=%0d exp=30", sent); end
    total++; if (atom_ready !== 1'b0) begin bad++; $display("FAIL bp_atom_ready: got=%b exp=0", atom_ready); end
    total++; if (dct_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got=%b exp=1", dct_valid); end
    total++; if (dct_buffer !== 30'h2AAAAAAA) begin bad++; $display("FAIL bp_held_buffer: got=%h exp=2aaaaaaa", dct_buffer); end
    total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL bp_held_count: got=%0d exp=15", dct_count); end
    dct_ready = 1'b1;
    @(negedge clk);
    total++; if (dct_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got=%b exp=1", dct_valid); end
    total++; if (dct_buffer !== 30'h3FFFFFFF) begin bad++; $display("FAIL b2b_buffer: got=%h exp=3fffffff", dct_buffer); end
    total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL b2b_count: got=%0d exp=15", dct_count); end
    total++; if (atom_ready !== 1'b1) begin bad++; $display("FAIL b2b_atom_ready: got=%b exp=1", atom_ready); end
    @(negedge clk);
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got=%b exp=0", dct_valid); end
  endtask

  task automatic test_flush_partial();
    dct_ready = 1'b1;
    send_atoms(1, 2'b11);
    send_atoms(1, 2'b10);
    send_atoms(1, 2'b01);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (test_ending !== 1'b1) begin bad++; $display("FAIL fl_ending: got=%b exp=1", test_ending); end
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL fl_early_valid: got=%b exp=0", dct_valid); end
    total++; if (atom_ready !== 1'b0) begin bad++; $display("FAIL fl_atom_ready: got=%b exp=0", atom_ready); end
    @(negedge clk);
    total++; if (dct_valid !== 1'b1) begin bad++; $display("FAIL fl_valid: got=%b exp=1", dct_valid); end
    total++; if (dct_buffer !== 30'h0000001B) begin bad++; $display("FAIL fl_buffer: got=%h exp=0000001b", dct_buffer); end
    total++; if (dct_count !== 4'd3) begin bad++; $display("FAIL fl_count: got=%0d exp=3", dct_count); end
    @(negedge clk);
    total++; if (test_ending !== 1'b1) begin bad++; $display("FAIL fl_ending_hold: got=%b exp=1", test_ending); end
    @(negedge clk);
    total++; if (test_ending !== 1'b0) begin bad++; $display("FAIL fl_ending_clear: got=%b exp=0", test_ending); end
    total++; if (test_has_ended !== 1'b1) begin bad++; $display("FAIL fl_ended: got=%b exp=1", test_has_ended); end
  endtask

  task automatic test_reset_midop();
    dct_ready = 1'b0;
    send_atoms(15, 2'b01);
    send_atoms(7, 2'b11);
    total++; if (dct_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got=%b exp=1", dct_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got=%b exp=0", dct_valid); end
    total++; if (dct_buffer !== 30'h0) begin bad++; $display("FAIL mid_buffer: got=%h exp=0", dct_buffer); end
    total++; if (dct_count !== 4'd0) begin bad++; $display("FAIL mid_count: got=%0d exp=0", dct_count); end
    total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL mid_ended: got=%b exp=0", test_has_ended); end
    @(negedge clk);
    reset_n = 1'b1;
    dct_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_valid[%0d]: got=%b exp=0", i, dct_valid); end
    end
    total++; if (atom_ready !== 1'b1) begin bad++; $display("FAIL mid_atom_ready: got=%b exp=1", atom_ready); end
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (test_ending !== 1'b1) begin bad++; $display("FAIL fe_ending: got=%b exp=1", test_ending); end
    total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL fe_ended_early: got=%b exp=0", test_has_ended); end
    @(negedge clk);
    total++; if (test_ending !== 1'b0) begin bad++; $display("FAIL fe_ending_clear: got=%b exp=0", test_ending); end
    total++; if (test_has_ended !== 1'b1) begin bad++; $display("FAIL fe_ended: got=%b exp=1", test_has_ended); end
    total++; if (dct_valid !== 1'b0) begin bad++; $display("FAIL fe_valid: got=%b exp=0", dct_valid); end
    send_atoms(1, 2'b10);
    total++; if (test_has_ended !== 1'b0) begin bad++; $display("FAIL fe_restart: got=%b exp=0", test_has_ended); end
    total++; if (test_ending !== 1'b0) begin bad++; $display("FAIL fe_restart_ending: got=%b exp=0", test_ending); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_flush_partial();
    test_reset_midop();
    test_flush_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
